// File: rtl/alu_pkg.sv
// Shared ALU opcode definitions used by the arbiter and its clients.
// ALU_ARB_OPCODE_CHECK_EN (in alu_arbiter) relies on alu_op_legal() below.
package alu_pkg;

    localparam int ALU_OPCODE_WIDTH = 3;

    typedef enum logic [ALU_OPCODE_WIDTH-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_MUL = 3'b010,
        ALU_EQ  = 3'b011,
        ALU_GT  = 3'b100
    } alu_op_e;

    function automatic logic alu_op_legal(input logic [ALU_OPCODE_WIDTH-1:0] op);
        return op inside {ALU_ADD, ALU_SUB, ALU_MUL, ALU_EQ, ALU_GT};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first valid requester
// at or after the pointer, wrapping from NUM_REQ-1 back to 0.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    pointer,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    int idx;

    // Scan from farthest to nearest so the requester closest to the pointer wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(pointer) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (valid[idx[ID_W-1:0]]) begin
                grant                   = '0;
                grant[idx[ID_W-1:0]]    = 1'b1;
                grant_idx               = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one registered ALU with an in-flight tag pipeline.
// Optional macro ALU_ARB_OPCODE_CHECK_EN: illegal opcodes are absorbed and answered with an error.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int ALU_LATENCY = 1
) (
    input  logic                                     clock_in,
    input  logic                                     reset_n_in,
    input  logic [NUM_REQ-1:0]                       req_valid_in,
    output logic [NUM_REQ-1:0]                       req_ready_out,
    input  logic [NUM_REQ-1:0][ALU_OPCODE_WIDTH-1:0] req_opcode_in,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]       req_operand1_in,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]       req_operand2_in,
    output logic                                     alu_enable_out,
    output logic [ALU_OPCODE_WIDTH-1:0]              alu_opcode_out,
    output logic [DATA_WIDTH-1:0]                    alu_input1_out,
    output logic [DATA_WIDTH-1:0]                    alu_input2_out,
    input  logic [DATA_WIDTH-1:0]                    alu_result_in,
    output logic                                     rsp_valid_out,
    output logic [$clog2(NUM_REQ)-1:0]               rsp_id_out,
    output logic [DATA_WIDTH-1:0]                    rsp_data_out,
    output logic                                     rsp_error_out,
    output logic                                     busy_out
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            err;
    } tag_t;

    logic [ID_W-1:0]             rr_ptr;
    logic [NUM_REQ-1:0]          grant;
    logic [ID_W-1:0]             grant_idx;
    logic                        grant_any;
    logic                        sel_legal;
    logic                        issue;
    logic [ALU_OPCODE_WIDTH-1:0] sel_op;
    tag_t                        new_tag;
    tag_t                        tag_out;
    tag_t                        tag_q [ALU_LATENCY+1];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .valid     (req_valid_in),
        .pointer   (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Ready is held low during reset so nothing is accepted while state is cleared.
    assign req_ready_out = reset_n_in ? grant : '0;
    assign grant_any     = |req_ready_out;
    assign sel_op        = req_opcode_in[grant_idx];

`ifdef ALU_ARB_OPCODE_CHECK_EN
    assign sel_legal = alu_op_legal(sel_op);
`else
    assign sel_legal = 1'b1;
`endif

    assign issue = grant_any & sel_legal;

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Operand registers only load on an issue, so the ALU inputs hold between operations.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            alu_enable_out <= 1'b0;
            alu_opcode_out <= '0;
            alu_input1_out <= '0;
            alu_input2_out <= '0;
        end else begin
            alu_enable_out <= issue;
            if (issue) begin
                alu_opcode_out <= sel_op;
                alu_input1_out <= req_operand1_in[grant_idx];
                alu_input2_out <= req_operand2_in[grant_idx];
            end
        end
    end

    always_comb begin
        new_tag       = '0;
        new_tag.valid = grant_any;
        new_tag.id    = grant_any ? grant_idx : '0;
        new_tag.err   = grant_any & ~sel_legal;
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            for (int k = 0; k <= ALU_LATENCY; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0] <= new_tag;
            for (int k = 1; k <= ALU_LATENCY; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    // The last tag stage lines up with the cycle in which the ALU result is valid.
    assign tag_out       = tag_q[ALU_LATENCY];
    assign rsp_valid_out = tag_out.valid;
    assign rsp_id_out    = tag_out.valid ? tag_out.id : '0;
    assign rsp_data_out  = (tag_out.valid && !tag_out.err) ? alu_result_in : '0;

`ifdef ALU_ARB_OPCODE_CHECK_EN
    assign rsp_error_out = tag_out.valid & tag_out.err;
`else
    assign rsp_error_out = 1'b0;
`endif

    always_comb begin
        busy_out = 1'b0;
        for (int k = 0; k <= ALU_LATENCY; k++) begin
            busy_out = busy_out | tag_q[k].valid;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: table vectors, hand sequences and an in-order scoreboard.
// Expectations follow ALU_ARB_OPCODE_CHECK_EN when the build defines it.
module tb_alu_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 8;
    localparam int LAT = 1;

    typedef struct {
        logic [2:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] exp;
        logic          err;
    } op_t;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        logic          err;
        int            due;
    } rsp_t;

    typedef struct {
        int            rid;
        logic [2:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] exp;
        logic          err;
    } vec_t;

    logic                   clock_in;
    logic                   reset_n_in;
    logic [NR-1:0]          req_valid;
    logic [NR-1:0]          req_ready_out;
    logic [NR-1:0][2:0]     req_op;
    logic [NR-1:0][DW-1:0]  req_a;
    logic [NR-1:0][DW-1:0]  req_b;
    logic                   alu_enable_out;
    logic [2:0]             alu_opcode_out;
    logic [DW-1:0]          alu_input1_out;
    logic [DW-1:0]          alu_input2_out;
    logic [DW-1:0]          alu_res_q;
    logic                   rsp_valid_out;
    logic [1:0]             rsp_id_out;
    logic [DW-1:0]          rsp_data_out;
    logic                   rsp_error_out;
    logic                   busy_out;

    int checks;
    int errors;

    op_t  req_q [NR][$];
    rsp_t sb[$];
    vec_t vecs[10];

    logic [DW-1:0] exp_data [NR];
    logic          exp_err  [NR];
    logic [NR-1:0] hs_mask;
    logic [NR-1:0] exp_gnt;
    logic          exp_en;
    logic [2:0]    exp_op;
    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;
    int            model_ptr;
    int            cycle;
    int            gidx;
    logic          found;
    rsp_t          e;
    op_t           cur;

    alu_arbiter #(
        .NUM_REQ     (NR),
        .DATA_WIDTH  (DW),
        .ALU_LATENCY (LAT)
    ) dut (
        .clock_in        (clock_in),
        .reset_n_in      (reset_n_in),
        .req_valid_in    (req_valid),
        .req_ready_out   (req_ready_out),
        .req_opcode_in   (req_op),
        .req_operand1_in (req_a),
        .req_operand2_in (req_b),
        .alu_enable_out  (alu_enable_out),
        .alu_opcode_out  (alu_opcode_out),
        .alu_input1_out  (alu_input1_out),
        .alu_input2_out  (alu_input2_out),
        .alu_result_in   (alu_res_q),
        .rsp_valid_out   (rsp_valid_out),
        .rsp_id_out      (rsp_id_out),
        .rsp_data_out    (rsp_data_out),
        .rsp_error_out   (rsp_error_out),
        .busy_out        (busy_out)
    );

    initial begin
        clock_in = 1'b0;
        forever #5 clock_in = ~clock_in;
    end

    function automatic logic [DW-1:0] alu_model(input logic [2:0] op, input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
        logic signed [15:0] p;
        p = $signed(a) * $signed(b);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return p[DW-1:0];
            3'b011:  return {7'b0, (a == b)};
            3'b100:  return {7'b0, ($signed(a) > $signed(b))};
            default: return 8'hEE;
        endcase
    endfunction

    function automatic op_t make_op(input logic [2:0] op, input logic [DW-1:0] a,
                                    input logic [DW-1:0] b);
        op_t o;
        o.op  = op;
        o.a   = a;
        o.b   = b;
        o.exp = alu_model(op, a, b);
        o.err = 1'b0;
`ifdef ALU_ARB_OPCODE_CHECK_EN
        if (op > 3'b100) begin
            o.exp = '0;
            o.err = 1'b1;
        end
`endif
        return o;
    endfunction

    // Registered ALU with one cycle of latency; idle cycles produce a marker value.
    always @(posedge clock_in) begin
        alu_res_q <= alu_enable_out ? alu_model(alu_opcode_out, alu_input1_out, alu_input2_out)
                                    : 8'h5A;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic apply_stimulus(input int rid, input op_t o);
        req_q[rid].push_back(o);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_ready"},  32'(req_ready_out),  32'd0);
        check_output({tag, "_en"},     32'(alu_enable_out), 32'd0);
        check_output({tag, "_op"},     32'(alu_opcode_out), 32'd0);
        check_output({tag, "_in1"},    32'(alu_input1_out), 32'd0);
        check_output({tag, "_in2"},    32'(alu_input2_out), 32'd0);
        check_output({tag, "_rvalid"}, 32'(rsp_valid_out),  32'd0);
        check_output({tag, "_rid"},    32'(rsp_id_out),     32'd0);
        check_output({tag, "_rdata"},  32'(rsp_data_out),   32'd0);
        check_output({tag, "_rerr"},   32'(rsp_error_out),  32'd0);
        check_output({tag, "_busy"},   32'(busy_out),       32'd0);
    endtask

    task automatic wait_drain(input string name);
        for (int n = 0; n < 300; n++) begin
            @(negedge clock_in);
            #1;
            if (sb.size() == 0 && req_valid == '0 && req_q[0].size() == 0 && req_q[1].size() == 0 &&
                req_q[2].size() == 0 && req_q[3].size() == 0) begin
                return;
            end
        end
        checks++;
        errors++;
        $display("[TB] FAIL %s drain timeout actual=pending required=idle", name);
    endtask

    // Driver: retire a transferred request after the edge and present the next queued one.
    initial begin
        forever begin
            @(posedge clock_in);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (hs_mask[i]) begin
                    req_valid[i] = 1'b0;
                end
                if (!req_valid[i] && req_q[i].size() != 0) begin
                    cur         = req_q[i].pop_front();
                    req_op[i]   = cur.op;
                    req_a[i]    = cur.a;
                    req_b[i]    = cur.b;
                    exp_data[i] = cur.exp;
                    exp_err[i]  = cur.err;
                    req_valid[i] = 1'b1;
                end
            end
        end
    end

    // Monitor: grant model, issue check and response scoreboard, sampled on the falling edge.
    initial begin
        model_ptr = 0;
        cycle     = 0;
        exp_en    = 1'b0;
        hs_mask   = '0;
        forever begin
            @(negedge clock_in);
            if (!reset_n_in) begin
                sb.delete();
                model_ptr = 0;
                exp_en    = 1'b0;
                hs_mask   = '0;
            end else begin
                found = 1'b0;
                gidx  = 0;
                for (int k = 0; k < NR; k++) begin
                    if (!found && req_valid[(model_ptr + k) % NR]) begin
                        found = 1'b1;
                        gidx  = (model_ptr + k) % NR;
                    end
                end
                exp_gnt = found ? (4'b0001 << gidx) : 4'b0000;
                check_output("ready", 32'(req_ready_out), 32'(exp_gnt));
                check_output("alu_enable", 32'(alu_enable_out), 32'(exp_en));
                if (exp_en) begin
                    check_output("alu_opcode", 32'(alu_opcode_out), 32'(exp_op));
                    check_output("alu_input1", 32'(alu_input1_out), 32'(exp_a));
                    check_output("alu_input2", 32'(alu_input2_out), 32'(exp_b));
                end
                check_output("busy", 32'(busy_out), 32'(sb.size() != 0));
                if (sb.size() != 0 && sb[0].due == cycle) begin
                    e = sb.pop_front();
                    check_output("rsp_valid", 32'(rsp_valid_out), 32'd1);
                    check_output("rsp_id",    32'(rsp_id_out),    32'(e.id));
                    check_output("rsp_data",  32'(rsp_data_out),  32'(e.data));
                    check_output("rsp_error", 32'(rsp_error_out), 32'(e.err));
                end else begin
                    check_output("rsp_idle_valid", 32'(rsp_valid_out), 32'd0);
                    check_output("rsp_idle_data",  32'(rsp_data_out),  32'd0);
                    check_output("rsp_idle_id",    32'(rsp_id_out),    32'd0);
                end
                hs_mask = req_valid & req_ready_out;
                exp_en  = 1'b0;
                if (found) begin
                    e.id   = gidx;
                    e.data = exp_data[gidx];
                    e.err  = exp_err[gidx];
                    e.due  = cycle + 1 + LAT;
                    sb.push_back(e);
                    model_ptr = (gidx + 1) % NR;
                    exp_en    = !exp_err[gidx];
                    exp_op    = req_op[gidx];
                    exp_a     = req_a[gidx];
                    exp_b     = req_b[gidx];
                end
            end
            cycle++;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        reset_n_in = 1'b1;
        req_valid  = '0;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;

        vecs[0] = '{0, 3'b000, 8'd100, 8'd27,  8'h7F, 1'b0};
        vecs[1] = '{1, 3'b010, 8'h80,  8'hFF,  8'h80, 1'b0};
        vecs[2] = '{2, 3'b100, 8'd5,   8'hFD,  8'h01, 1'b0};
        vecs[3] = '{3, 3'b011, 8'hF9,  8'hF9,  8'h01, 1'b0};
        vecs[4] = '{1, 3'b001, 8'd10,  8'd20,  8'hF6, 1'b0};
        vecs[5] = '{2, 3'b100, 8'hFD,  8'd5,   8'h00, 1'b0};
        vecs[6] = '{0, 3'b011, 8'd3,   8'd4,   8'h00, 1'b0};
        vecs[7] = '{3, 3'b000, 8'd127, 8'd1,   8'h80, 1'b0};
        vecs[8] = '{2, 3'b010, 8'd16,  8'd16,  8'h00, 1'b0};
`ifdef ALU_ARB_OPCODE_CHECK_EN
        vecs[9] = '{1, 3'b110, 8'd1,   8'd2,   8'h00, 1'b1};
`else
        vecs[9] = '{1, 3'b110, 8'd1,   8'd2,   8'hEE, 1'b0};
`endif

        #2 reset_n_in = 1'b0;
        #1 check_reset_outputs("por");
        repeat (2) @(negedge clock_in);
        #2 reset_n_in = 1'b1;
        @(negedge clock_in);

        $display("[TB] reset mid-stream");
        apply_stimulus(0, make_op(3'b000, 8'd1, 8'd2));
        apply_stimulus(1, make_op(3'b001, 8'd9, 8'd4));
        apply_stimulus(2, make_op(3'b010, 8'd3, 8'd3));
        repeat (3) @(negedge clock_in);
        #2 reset_n_in = 1'b0;
        #1 check_reset_outputs("midrst");
        for (int i = 0; i < NR; i++) req_q[i].delete();
        req_valid = '0;
        @(negedge clock_in);
        #2 reset_n_in = 1'b1;
        @(negedge clock_in);
        apply_stimulus(1, make_op(3'b000, 8'd4, 8'd4));
        apply_stimulus(3, make_op(3'b000, 8'd5, 8'd5));
        @(negedge clock_in);
        check_output("ptr_after_reset", 32'(req_ready_out), 32'b0010);
        wait_drain("after_reset");

        $display("[TB] table vectors");
        for (int v = 0; v < 10; v++) begin
            cur.op  = vecs[v].op;
            cur.a   = vecs[v].a;
            cur.b   = vecs[v].b;
            cur.exp = vecs[v].exp;
            cur.err = vecs[v].err;
            apply_stimulus(vecs[v].rid, cur);
            wait_drain("vector");
        end

        $display("[TB] all requesters streaming");
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < NR; i++) begin
                apply_stimulus(i, make_op(3'b001, 8'(i), 8'(j)));
            end
        end
        wait_drain("stream");

        $display("[TB] wrap and fairness");
        apply_stimulus(2, make_op(3'b000, 8'd1, 8'd1));
        wait_drain("set_ptr3");
        apply_stimulus(3, make_op(3'b000, 8'd7, 8'd8));
        apply_stimulus(3, make_op(3'b001, 8'd7, 8'd8));
        apply_stimulus(1, make_op(3'b100, 8'd7, 8'd8));
        @(negedge clock_in);
        check_output("wrap_first",  32'(req_ready_out), 32'b1000);
        @(negedge clock_in);
        check_output("wrap_second", 32'(req_ready_out), 32'b0010);
        @(negedge clock_in);
        check_output("wrap_third",  32'(req_ready_out), 32'b1000);
        wait_drain("wrap");

        $display("[TB] random burst");
        for (int n = 0; n < 16; n++) begin
            apply_stimulus(int'($urandom_range(0, NR - 1)),
                           make_op(3'($urandom_range(0, 4)), 8'($urandom), 8'($urandom)));
        end
        wait_drain("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
